// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer and its digit cells.
package timer_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    SET  = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam digit_t BCD_MAX      = 4'd9;
  localparam digit_t SEC_TENS_MAX = 4'd5;

  function automatic logic isValidBcd(input digit_t value);
    return (value <= BCD_MAX);
  endfunction

endpackage

// File: rtl/timer_bcd_digit_down.sv
// One BCD down-counting digit: decrements when a borrow arrives and reloads
// to its maximum (passing the borrow on) when it underflows from zero.
module bcd_digit_down
  import timer_pkg::*;
(
  input  digit_t i_value,
  input  digit_t i_max,
  input  logic   i_borrowIn,
  output digit_t o_next,
  output logic   o_borrowOut
);

  // A nonzero digit absorbs the borrow, so typed values above i_max still count down by one.
  always_comb begin
    o_next      = i_value;
    o_borrowOut = 1'b0;
    if (i_borrowIn) begin
      if (i_value == 4'd0) begin
        o_next      = i_max;
        o_borrowOut = 1'b1;
      end else begin
        o_next = i_value - 4'd1;
      end
    end
  end

endmodule

// File: rtl/timer.sv
// Keypad-loaded MM:SS countdown timer with SET/RUN/DONE control and a
// synchronized load/countdown strobe.
module timer
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] BCD_IN,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       clearn,
  input  logic       enablen,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       zero,
  output logic       running,
  output logic       done
);

  logic   r_pgtSync1, r_pgtSync2, r_pgtPrev;
  logic   r_loadnSync1, r_loadnSync2;
  digit_t r_bcdSync1, r_bcdSync2;
  logic   w_tick;

  digit_t r_secOnes, r_secTens, r_minOnes, r_minTens;
  digit_t w_secOnesNext, w_secTensNext, w_minOnesNext, w_minTensNext;
  digit_t w_decSecOnes, w_decSecTens, w_decMinOnes, w_decMinTens;
  logic   w_borrowSecOnes, w_borrowSecTens, w_borrowMinOnes, w_borrowMinTens;

  state_t r_state, w_stateNext;
  logic   r_done, w_doneNext;
  logic   w_zero;

  // Strobe, key-valid and digit share one synchronizer depth so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pgtSync1   <= 1'b0;
      r_pgtSync2   <= 1'b0;
      r_pgtPrev    <= 1'b0;
      r_loadnSync1 <= 1'b0;
      r_loadnSync2 <= 1'b0;
      r_bcdSync1   <= 4'd0;
      r_bcdSync2   <= 4'd0;
    end else begin
      r_pgtSync1   <= pgt_1hz;
      r_pgtSync2   <= r_pgtSync1;
      r_pgtPrev    <= r_pgtSync2;
      r_loadnSync1 <= loadn;
      r_loadnSync2 <= r_loadnSync1;
      r_bcdSync1   <= BCD_IN;
      r_bcdSync2   <= r_bcdSync1;
    end
  end

  assign w_tick = r_pgtSync2 & ~r_pgtPrev;
  assign w_zero = (r_secOnes == 4'd0) && (r_secTens == 4'd0) &&
                  (r_minOnes == 4'd0) && (r_minTens == 4'd0);

  bcd_digit_down u_secOnes (
    .i_value     (r_secOnes),
    .i_max       (BCD_MAX),
    .i_borrowIn  (1'b1),
    .o_next      (w_decSecOnes),
    .o_borrowOut (w_borrowSecOnes)
  );

  bcd_digit_down u_secTens (
    .i_value     (r_secTens),
    .i_max       (SEC_TENS_MAX),
    .i_borrowIn  (w_borrowSecOnes),
    .o_next      (w_decSecTens),
    .o_borrowOut (w_borrowSecTens)
  );

  bcd_digit_down u_minOnes (
    .i_value     (r_minOnes),
    .i_max       (BCD_MAX),
    .i_borrowIn  (w_borrowSecTens),
    .o_next      (w_decMinOnes),
    .o_borrowOut (w_borrowMinOnes)
  );

  bcd_digit_down u_minTens (
    .i_value     (r_minTens),
    .i_max       (BCD_MAX),
    .i_borrowIn  (w_borrowMinOnes),
    .o_next      (w_decMinTens),
    .o_borrowOut (w_borrowMinTens)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SET;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Clear outranks everything; a pause in RUN outranks a same-cycle tick.
  // A borrow out of the top digit means 00:00, so the count never wraps.
  always_comb begin
    w_stateNext   = r_state;
    w_doneNext    = 1'b0;
    w_secOnesNext = r_secOnes;
    w_secTensNext = r_secTens;
    w_minOnesNext = r_minOnes;
    w_minTensNext = r_minTens;
    if (!clearn) begin
      w_stateNext   = SET;
      w_secOnesNext = 4'd0;
      w_secTensNext = 4'd0;
      w_minOnesNext = 4'd0;
      w_minTensNext = 4'd0;
    end else begin
      case (r_state)
        SET: begin
          if (w_tick && !r_loadnSync2 && isValidBcd(r_bcdSync2)) begin
            w_minTensNext = r_minOnes;
            w_minOnesNext = r_secTens;
            w_secTensNext = r_secOnes;
            w_secOnesNext = r_bcdSync2;
          end
          if (!enablen && !w_zero) begin
            w_stateNext = RUN;
          end
        end
        RUN: begin
          if (enablen) begin
            w_stateNext = SET;
          end else if (w_tick && !w_borrowMinTens) begin
            w_secOnesNext = w_decSecOnes;
            w_secTensNext = w_decSecTens;
            w_minOnesNext = w_decMinOnes;
            w_minTensNext = w_decMinTens;
            if ((w_decSecOnes == 4'd0) && (w_decSecTens == 4'd0) &&
                (w_decMinOnes == 4'd0) && (w_decMinTens == 4'd0)) begin
              w_stateNext = DONE;
              w_doneNext  = 1'b1;
            end
          end
        end
        DONE: begin
          if (enablen) begin
            w_stateNext = SET;
          end
        end
        default: begin
          w_stateNext = SET;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_secOnes <= 4'd0;
      r_secTens <= 4'd0;
      r_minOnes <= 4'd0;
      r_minTens <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_secOnes <= w_secOnesNext;
      r_secTens <= w_secTensNext;
      r_minOnes <= w_minOnesNext;
      r_minTens <= w_minTensNext;
      r_done    <= w_doneNext;
    end
  end

  assign sec_ones = r_secOnes;
  assign sec_tens = r_secTens;
  assign min_ones = r_minOnes;
  assign min_tens = r_minTens;
  assign zero     = w_zero;
  assign running  = (r_state == RUN);
  assign done     = r_done;

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 BCD_IN  input  4  keypad digit from the encoder stage; values 0-9 are valid.
REQ-004 loadn  input  1  key-valid from the encoder; low means BCD_IN holds a pressed key.
REQ-005 pgt_1hz  input  1  strobe from the encoder; its rising edge is the load or countdown event.
REQ-006 clearn  input  1  synchronous clear, active-low.
REQ-007 enablen  input  1  run request, active-low; high means stopped or setting.
REQ-008 sec_ones, sec_tens, min_ones, min_tens  output  4 each  BCD display digits MM:SS.
REQ-009 zero  output  1  high when all four digits equal 0.
REQ-010 running  output  1  high while the FSM is in RUN.
REQ-011 done  output  1  one-cycle pulse when a countdown reaches 00:00.

Function
REQ-012 pgt_1hz, loadn and BCD_IN SHALL pass through an identical 2-flop synchronizer so they stay aligned.
REQ-013 A previous-value flop on synchronized pgt_1hz SHALL produce tick = sync & ~prev, one clk cycle wide.
REQ-014 Digit registers SHALL update on the clk edge after tick, 3 clk edges after pgt_1hz rises.
REQ-015 The FSM SHALL have three states: SET, RUN, DONE.
REQ-016 Load rule: in SET, a tick with synchronized loadn=0 and BCD_IN<=9 SHALL shift the digits left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=BCD_IN.
REQ-017 BCD_IN >9, or loadn=1 at tick, SHALL leave the digits unchanged; the shifted-out min_tens is discarded.
REQ-018 Load ticks in RUN or DONE SHALL be ignored.
REQ-019 SET->RUN SHALL occur when enablen=0 and zero=0; with zero=1 the FSM SHALL stay in SET.
REQ-020 RUN->SET SHALL occur when enablen=1 (pause); digits are retained, and later loads shift into the retained value.
REQ-021 Countdown: in RUN, each tick SHALL decrement MM:SS by one second.
REQ-022 Decrement order: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones; min_ones 0->9 borrows from min_tens.
REQ-023 A digit >0 SHALL decrement by 1 with no borrow, so a typed sec_tens of 6-9 counts down normally (01:99 -> 01:98).
REQ-024 When a tick takes the count from nonzero to 00:00, the FSM SHALL enter DONE and assert done for exactly one cycle.
REQ-025 In DONE the digits SHALL hold 00:00 and ticks SHALL be ignored; enablen=1 SHALL move DONE->SET.
REQ-026 Countdown SHALL never wrap below 00:00.
REQ-027 clearn=0 SHALL force the digits to 0 and the state to SET, with priority over tick and enablen.
REQ-028 zero and running SHALL be combinational decodes of the registers; done SHALL be registered.
REQ-029 If enablen=1 and a tick occur in the same RUN cycle, the state change SHALL win and no decrement SHALL occur.

Reset
REQ-030 rst=1 SHALL asynchronously force: digits 0, state SET, synchronizer and prev flops 0, done 0.
REQ-031 Resulting outputs during reset: zero=1, running=0.
REQ-032 Reset asserted mid-countdown SHALL abort immediately; no done pulse SHALL be produced.
REQ-033 Reset deassertion SHALL take effect synchronously to clk.

Structure
REQ-034 Shared package timer_pkg SHALL hold the state enum (SET, RUN, DONE), BCD_MAX=9, SEC_TENS_MAX=5 and the 4-bit digit type.
REQ-035 One sub-module, bcd_digit_down, SHALL implement a single digit: inputs value, max, borrow_in; outputs next value, borrow_out.
REQ-036 timer SHALL instantiate bcd_digit_down four times.

Verification
REQ-037 Keys 1,2,3,0 each on a pgt_1hz edge with loadn=0 -> digits 12:30; zero=0.
REQ-038 Load 00:02, enablen=0, 2 ticks -> 00:01 then 00:00; done pulses once; state DONE; a third tick leaves 00:00.
REQ-039 Load 10:00, 1 tick in RUN -> 09:59; load 01:99, 1 tick -> 01:98.
REQ-040 RUN at 05:00, enablen=1 then key 7 -> digits 50:07, state SET.
REQ-041 clearn=0 during RUN at 03:15 -> 00:00, SET, no done; rst mid-RUN -> all outputs at reset values at once.
REQ-042 BCD_IN=12 with loadn=0 at tick -> digits unchanged; pgt_1hz held high several cycles -> exactly one tick.
